// File: rtl/sxtn_bit_adder_reg.sv
// 16-bit carry-lookahead adder, four 4-bit slices,
// with a single registered, valid-tagged output stage.
module sxtn_bit_adder_reg #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ca,
  output logic             out_valid
);

  localparam int NS = WIDTH / SLICE_W;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_c;
  logic [NS-1:0]    gg;
  logic [NS-1:0]    pg;
  logic [NS:0]      cs;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    localparam int L = s * SLICE_W;
    logic [SLICE_W-1:0] gs;
    logic [SLICE_W-1:0] ps;
    logic               ci;

    assign gs = g[L +: SLICE_W];
    assign ps = p[L +: SLICE_W];
    assign ci = cs[s];

    assign c[L]   = ci;
    assign c[L+1] = gs[0]
                  | (ps[0] & ci);
    assign c[L+2] = gs[1]
                  | (ps[1] & gs[0])
                  | (ps[1] & ps[0] & ci);
    assign c[L+3] = gs[2]
                  | (ps[2] & gs[1])
                  | (ps[2] & ps[1] & gs[0])
                  | (ps[2] & ps[1] & ps[0] & ci);

    assign gg[s] = gs[3]
                 | (ps[3] & gs[2])
                 | (ps[3] & ps[2] & gs[1])
                 | (ps[3] & ps[2] & ps[1] & gs[0]);
    assign pg[s] = &ps;
  end

  // Inter-slice carries, fully expanded from group G/P.
  assign cs[0] = cin;
  assign cs[1] = gg[0]
               | (pg[0] & cin);
  assign cs[2] = gg[1]
               | (pg[1] & gg[0])
               | (pg[1] & pg[0] & cin);
  assign cs[3] = gg[2]
               | (pg[2] & gg[1])
               | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign cs[4] = gg[3]
               | (pg[3] & gg[2])
               | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

  assign sum_c = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      ca        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_c;
        ca  <= cs[NS];
      end
    end
  end

endmodule

// File: tb/tb_sxtn_bit_adder_reg.sv
// Bench for sxtn_bit_adder_reg: directed literals plus
// an arithmetic reference model compared every cycle.
module tb_sxtn_bit_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic [15:0] sum;
  logic        ca;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_sum = '0;
  logic        m_ca = 1'b0;
  logic        m_valid = 1'b0;

  sxtn_bit_adder_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .ca        (ca),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: exact 17-bit sum of what was driven at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum   <= '0;
      m_ca    <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid)
        {m_ca, m_sum} <= 17'(a) + 17'(b) + 17'(cin);
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_sum", 32'(sum), 32'(m_sum));
    chk("model_ca", 32'(ca), 32'(m_ca));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
  end

  task automatic step(input logic v,
                      input logic [15:0] av,
                      input logic [15:0] bv,
                      input logic ci);
    in_valid = v;
    a = av;
    b = bv;
    cin = ci;
    @(negedge clk);
  endtask

  task automatic expect_out(input string n,
                            input logic [15:0] s,
                            input logic c,
                            input logic v);
    chk({n, "_sum"}, 32'(sum), 32'(s));
    chk({n, "_ca"}, 32'(ca), 32'(c));
    chk({n, "_valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    in_valid = 1'b1;
    a = 16'd5;
    b = 16'd7;
    #1 rst_n = 1'b0;
    #1 expect_out("rst_async", 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    expect_out("rst_hold", 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    step(1'b1, 16'd0, 16'd0, 1'b1);
    expect_out("zero_cin", 16'd1, 1'b0, 1'b1);
    step(1'b1, 16'd32, 16'd16, 1'b0);
    expect_out("add_48", 16'd48, 1'b0, 1'b1);
    step(1'b1, 16'd256, 16'd0, 1'b1);
    expect_out("add_257", 16'd257, 1'b0, 1'b1);
    step(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    expect_out("hold_257", 16'd257, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_out("hold2_257", 16'd257, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    expect_out("wrap", 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_out("max", 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'h0FFF, 16'h0001, 1'b0);
    expect_out("slice3", 16'h1000, 1'b0, 1'b1);
    step(1'b1, 16'h00FF, 16'h0000, 1'b1);
    expect_out("slice2", 16'h0100, 1'b0, 1'b1);
    step(1'b1, 16'h000F, 16'h0000, 1'b1);
    expect_out("slice1", 16'h0010, 1'b0, 1'b1);
    step(1'b1, 16'hF0F0, 16'h0F10, 1'b0);
    expect_out("gen_chain", 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0000, 1'b1);
    expect_out("prop_chain", 16'h8000, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 16'h4321, 1'b1);
    expect_out("mixed", 16'h5556, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom),
           1'($urandom));
      if (!out_valid) begin
        checks++;
        failures++;
        $display("FAIL b2b_valid got=0 exp=1 i=%0d", i);
      end
    end

    step(1'b1, 16'd100, 16'd200, 1'b0);
    expect_out("pre_rst", 16'd300, 1'b0, 1'b1);
    in_valid = 1'b1;
    a = 16'd1000;
    b = 16'd1;
    cin = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_out("mid_rst", 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst_discard", 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 16'd3, 16'd4, 1'b0);
    expect_out("post_rst", 16'd7, 1'b0, 1'b1);
    step(1'b0, 16'd0, 16'd0, 1'b0);
    expect_out("post_hold", 16'd7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
